// File: rtl/ps2_pkg.sv
// Shared types and byte constants for the PS/2 Set-2 scan-code parser.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXT     = 3'd1,
        BRK     = 3'd2,
        EXT_BRK = 3'd3,
        PAUSE   = 3'd4
    } parser_state_t;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] PS2_PAUSE     = 8'hE1;
    localparam logic [7:0] PS2_BAT       = 8'hAA;
    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_ECHO      = 8'hEE;
    localparam logic [7:0] PS2_OVR0      = 8'h00;
    localparam logic [7:0] PS2_OVR1      = 8'hFF;
    localparam logic [7:0] PS2_FAKESHIFT = 8'h12;

    // E1 prefix plus seven follow-up bytes.
    localparam int PAUSE_LEN = 8;

    // Keyboard buffer overrun markers.
    function automatic logic is_overrun(input logic [7:0] b);
        return (b == PS2_OVR0) || (b == PS2_OVR1);
    endfunction

    // Controller replies that carry no key information.
    function automatic logic is_status(input logic [7:0] b);
        return (b == PS2_BAT) || (b == PS2_ACK) || (b == PS2_RESEND) || (b == PS2_ECHO);
    endfunction

endpackage

// File: rtl/ps2_scancode_parser_if.sv
// Signal bundle between the parser and its byte source / event consumer.
//
// Handshake: code_valid_in is a one-cycle strobe with no back-pressure; the
// parser accepts a byte on every cycle it is high. key_valid_out, pause_out
// and err_out are one-cycle strobes; key_code/ext/break/repeat hold their
// last event value between strobes. The query is a registered lookup with
// one cycle of latency.
interface ps2_scancode_parser_if;
    import ps2_pkg::*;

    logic [7:0]    code_in;
    logic          code_valid_in;
    logic [7:0]    key_code_out;
    logic          key_ext_out;
    logic          key_break_out;
    logic          key_repeat_out;
    logic          key_valid_out;
    logic          pause_out;
    logic          err_out;
    logic [7:0]    query_code_in;
    logic          query_ext_in;
    logic          query_pressed_out;
    parser_state_t state_dbg;

    // Parser side.
    modport slave (
        input  code_in, code_valid_in, query_code_in, query_ext_in,
        output key_code_out, key_ext_out, key_break_out, key_repeat_out,
               key_valid_out, pause_out, err_out, query_pressed_out, state_dbg
    );

    // Byte source / event consumer side.
    modport master (
        output code_in, code_valid_in, query_code_in, query_ext_in,
        input  key_code_out, key_ext_out, key_break_out, key_repeat_out,
               key_valid_out, pause_out, err_out, query_pressed_out, state_dbg
    );

endinterface

// File: rtl/ps2_key_bitmap.sv
// 512x1 pressed-key map indexed by {ext, code}: one set/clear write port and
// two registered read ports (repeat check and external query). Reads return
// the value before a same-cycle write.
module ps2_key_bitmap (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       wr_en,
    input  logic       wr_set,
    input  logic [8:0] wr_idx,
    input  logic [8:0] chk_idx,
    output logic       chk_pressed,
    input  logic [8:0] qry_idx,
    output logic       qry_pressed
);

    logic [511:0] bits_q;

    // Storage: a make sets the key bit, a break clears it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bits_q <= '0;
        end else if (wr_en) begin
            bits_q[wr_idx] <= wr_set;
        end
    end

    // Registered read ports, sampled from the pre-write contents.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            chk_pressed <= 1'b0;
            qry_pressed <= 1'b0;
        end else begin
            chk_pressed <= bits_q[chk_idx];
            qry_pressed <= bits_q[qry_idx];
        end
    end

endmodule

// File: rtl/ps2_scancode_parser.sv
// Turns raw Set-2 scan-code bytes into key events (code, extended, make/break),
// detects the E1 pause sequence, suppresses or flags typematic repeats and
// answers "is key held" queries from a pressed-key bitmap.
module ps2_scancode_parser
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES  = 2_000_000,
    parameter bit          SUPPRESS_REPEAT = 1'b1
) (
    input logic                    clk_in,
    input logic                    rst_in,
    ps2_scancode_parser_if.slave   bus
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    parser_state_t state_q, state_n;
    logic [3:0]    pcnt_q, pcnt_n;
    logic [TW-1:0] to_q, to_n;
    logic          ev_v_n, ev_ext_n, ev_brk_n, err_n, pause_n;
    logic [7:0]    ev_code_n;

    // Candidate event, one cycle after the completing byte.
    logic          ev_v_q, ev_ext_q, ev_brk_q;
    logic [7:0]    ev_code_q;
    logic          err_q, pause_q;
    logic          pressed, is_rep, emit;
    logic [7:0]    hold_code_q;
    logic          hold_ext_q, hold_brk_q, hold_rep_q;

    // State, pause count, timeout count and registered strobes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            to_q      <= '0;
            ev_v_q    <= 1'b0;
            ev_code_q <= '0;
            ev_ext_q  <= 1'b0;
            ev_brk_q  <= 1'b0;
            err_q     <= 1'b0;
            pause_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            pcnt_q    <= pcnt_n;
            to_q      <= to_n;
            ev_v_q    <= ev_v_n;
            ev_code_q <= ev_code_n;
            ev_ext_q  <= ev_ext_n;
            ev_brk_q  <= ev_brk_n;
            err_q     <= err_n;
            pause_q   <= pause_n;
        end
    end

    // Prefix decoding, pause skipping and prefix timeout.
    always_comb begin
        state_n   = state_q;
        pcnt_n    = pcnt_q;
        to_n      = to_q;
        ev_v_n    = 1'b0;
        ev_code_n = bus.code_in;
        ev_ext_n  = 1'b0;
        ev_brk_n  = 1'b0;
        err_n     = 1'b0;
        pause_n   = 1'b0;
        if (bus.code_valid_in) begin
            to_n = '0;
            case (state_q)
                IDLE: begin
                    if (bus.code_in == PS2_EXT) begin
                        state_n = EXT;
                    end else if (bus.code_in == PS2_BRK) begin
                        state_n = BRK;
                    end else if (bus.code_in == PS2_PAUSE) begin
                        state_n = PAUSE;
                        pcnt_n  = 4'd1;
                    end else if (is_overrun(bus.code_in)) begin
                        err_n = 1'b1;
                    end else if (!is_status(bus.code_in)) begin
                        ev_v_n = 1'b1;
                    end
                end
                EXT: begin
                    state_n = IDLE;
                    if (is_overrun(bus.code_in)) begin
                        err_n = 1'b1;
                    end else if (bus.code_in == PS2_BRK) begin
                        state_n = EXT_BRK;
                    end else if (bus.code_in != PS2_FAKESHIFT) begin
                        ev_v_n   = 1'b1;
                        ev_ext_n = 1'b1;
                    end
                end
                BRK: begin
                    state_n = IDLE;
                    if (is_overrun(bus.code_in)) begin
                        err_n = 1'b1;
                    end else begin
                        ev_v_n   = 1'b1;
                        ev_brk_n = 1'b1;
                    end
                end
                EXT_BRK: begin
                    state_n = IDLE;
                    if (is_overrun(bus.code_in)) begin
                        err_n = 1'b1;
                    end else if (bus.code_in != PS2_FAKESHIFT) begin
                        ev_v_n   = 1'b1;
                        ev_ext_n = 1'b1;
                        ev_brk_n = 1'b1;
                    end
                end
                PAUSE: begin
                    if (pcnt_q == 4'(PAUSE_LEN - 1)) begin
                        pause_n = 1'b1;
                        pcnt_n  = '0;
                        state_n = IDLE;
                    end else begin
                        pcnt_n = pcnt_q + 4'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            if (to_q == TO_LAST) begin
                state_n = IDLE;
                err_n   = 1'b1;
                to_n    = '0;
                pcnt_n  = '0;
            end else begin
                to_n = to_q + 1'b1;
            end
        end
    end

    // The map is written with the decoded event straight away; the check port
    // reads the same index, so the next cycle sees the pre-event pressed state.
    ps2_key_bitmap u_bitmap (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .wr_en       (ev_v_n),
        .wr_set      (~ev_brk_n),
        .wr_idx      ({ev_ext_n, ev_code_n}),
        .chk_idx     ({ev_ext_n, ev_code_n}),
        .chk_pressed (pressed),
        .qry_idx     ({bus.query_ext_in, bus.query_code_in}),
        .qry_pressed (bus.query_pressed_out)
    );

    assign is_rep = ev_v_q & ~ev_brk_q & pressed;
    assign emit   = ev_v_q & ~(is_rep & SUPPRESS_REPEAT);

    // Event fields hold their last emitted value between strobes.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_code_q <= '0;
            hold_ext_q  <= 1'b0;
            hold_brk_q  <= 1'b0;
            hold_rep_q  <= 1'b0;
        end else if (emit) begin
            hold_code_q <= ev_code_q;
            hold_ext_q  <= ev_ext_q;
            hold_brk_q  <= ev_brk_q;
            hold_rep_q  <= is_rep;
        end
    end

    assign bus.key_valid_out  = emit;
    assign bus.key_code_out   = emit ? ev_code_q : hold_code_q;
    assign bus.key_ext_out    = emit ? ev_ext_q  : hold_ext_q;
    assign bus.key_break_out  = emit ? ev_brk_q  : hold_brk_q;
    assign bus.key_repeat_out = emit ? is_rep    : hold_rep_q;
    assign bus.err_out        = err_q;
    assign bus.pause_out      = pause_q;
    assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_ps2_scancode_parser.sv
// Bench for ps2_scancode_parser: two instances share one byte stream, one
// suppressing repeats (a) and one flagging them (b).
module tb_ps2_scancode_parser;
    import ps2_pkg::*;

    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ps2_scancode_parser_if ifa ();
    ps2_scancode_parser_if ifb ();

    ps2_scancode_parser #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b1)) dut_a (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (ifa)
    );

    ps2_scancode_parser #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b0)) dut_b (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (ifb)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Scoreboard: expected events {rep, brk, ext, code}.
    logic [10:0] exp_a[$];
    logic [10:0] exp_b[$];
    logic [7:0]  byte_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int err_a = 0, err_b = 0, pause_a = 0, pause_b = 0;
    int exp_err = 0, exp_pause = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] ev(input logic [7:0] code, input logic ext,
                                       input logic brk, input logic rep);
        return {rep, brk, ext, code};
    endfunction

    // Output monitor: pop and compare on every event, count strobes.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.key_valid_out) begin
                if (exp_a.size() == 0)
                    check("ev_a_extra", {21'b0, ifa.key_repeat_out, ifa.key_break_out,
                          ifa.key_ext_out, ifa.key_code_out}, 32'hFFFF_FFFF);
                else
                    check("ev_a", {21'b0, ifa.key_repeat_out, ifa.key_break_out,
                          ifa.key_ext_out, ifa.key_code_out}, {21'b0, exp_a.pop_front()});
            end
            if (ifb.key_valid_out) begin
                if (exp_b.size() == 0)
                    check("ev_b_extra", {21'b0, ifb.key_repeat_out, ifb.key_break_out,
                          ifb.key_ext_out, ifb.key_code_out}, 32'hFFFF_FFFF);
                else
                    check("ev_b", {21'b0, ifb.key_repeat_out, ifb.key_break_out,
                          ifb.key_ext_out, ifb.key_code_out}, {21'b0, exp_b.pop_front()});
            end
            if (ifa.err_out)   err_a++;
            if (ifb.err_out)   err_b++;
            if (ifa.pause_out) pause_a++;
            if (ifb.pause_out) pause_b++;
        end
    end

    // Driver tasks.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bytes();
        while (byte_q.size() > 0) begin
            @(posedge clk);
            #1;
            ifa.code_in       = byte_q[0];
            ifb.code_in       = byte_q[0];
            ifa.code_valid_in = 1'b1;
            ifb.code_valid_in = 1'b1;
            void'(byte_q.pop_front());
        end
        @(posedge clk);
        #1;
        ifa.code_valid_in = 1'b0;
        ifb.code_valid_in = 1'b0;
        ifa.code_in       = 8'($urandom_range(0, 255));
        ifb.code_in       = ifa.code_in;
        idle(3);
    endtask

    task automatic push_both(input logic [10:0] e);
        exp_a.push_back(e);
        exp_b.push_back(e);
    endtask

    task automatic query(input logic ext, input logic [7:0] code, input logic exp);
        @(posedge clk);
        #1;
        ifa.query_ext_in  = ext;
        ifa.query_code_in = code;
        ifb.query_ext_in  = ext;
        ifb.query_code_in = code;
        @(posedge clk);
        @(negedge clk);
        check("query_a", {31'b0, ifa.query_pressed_out}, {31'b0, exp});
        check("query_b", {31'b0, ifb.query_pressed_out}, {31'b0, exp});
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_err_a"},   err_a,   exp_err);
        check({tag, "_err_b"},   err_b,   exp_err);
        check({tag, "_pause_a"}, pause_a, exp_pause);
        check({tag, "_pause_b"}, pause_b, exp_pause);
        check({tag, "_idle_a"},  {29'b0, ifa.state_dbg}, {29'b0, IDLE});
        check({tag, "_idle_b"},  {29'b0, ifb.state_dbg}, {29'b0, IDLE});
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    initial begin
        ifa.code_in = '0; ifa.code_valid_in = 1'b0;
        ifa.query_code_in = '0; ifa.query_ext_in = 1'b0;
        ifb.code_in = '0; ifb.code_valid_in = 1'b0;
        ifb.query_code_in = '0; ifb.query_ext_in = 1'b0;
        idle(4);
        rst = 1'b0;
        idle(1);

        // Reset state.
        check("rst_valid", {31'b0, ifa.key_valid_out}, 32'd0);
        check("rst_code",  {24'b0, ifa.key_code_out}, 32'd0);
        check("rst_err",   {31'b0, ifa.err_out}, 32'd0);
        check("rst_pause", {31'b0, ifa.pause_out}, 32'd0);
        check("rst_state", {29'b0, ifa.state_dbg}, {29'b0, IDLE});

        // Plain make, then held.
        byte_q = '{8'h1C};
        push_both(ev(8'h1C, 1'b0, 1'b0, 1'b0));
        drive_bytes();
        query(1'b0, 8'h1C, 1'b1);

        // Break.
        byte_q = '{8'hF0, 8'h1C};
        push_both(ev(8'h1C, 1'b0, 1'b1, 1'b0));
        drive_bytes();
        query(1'b0, 8'h1C, 1'b0);

        // Extended make and break.
        byte_q = '{8'hE0, 8'h75};
        push_both(ev(8'h75, 1'b1, 1'b0, 1'b0));
        drive_bytes();
        query(1'b1, 8'h75, 1'b1);
        query(1'b0, 8'h75, 1'b0);
        byte_q = '{8'hE0, 8'hF0, 8'h75};
        push_both(ev(8'h75, 1'b1, 1'b1, 1'b0));
        drive_bytes();
        query(1'b1, 8'h75, 1'b0);

        // Typematic repeats, back-to-back.
        byte_q = '{8'h1C, 8'h1C, 8'h1C};
        exp_a.push_back(ev(8'h1C, 1'b0, 1'b0, 1'b0));
        exp_b.push_back(ev(8'h1C, 1'b0, 1'b0, 1'b0));
        exp_b.push_back(ev(8'h1C, 1'b0, 1'b0, 1'b1));
        exp_b.push_back(ev(8'h1C, 1'b0, 1'b0, 1'b1));
        drive_bytes();
        byte_q = '{8'hF0, 8'h1C};
        push_both(ev(8'h1C, 1'b0, 1'b1, 1'b0));
        drive_bytes();
        query(1'b0, 8'h1C, 1'b0);

        // Dropped bytes, fake shifts, overruns.
        byte_q = '{8'hAA, 8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h12};
        drive_bytes();
        check_counts("drop");
        byte_q = '{8'hF0, 8'h00, 8'h00};
        exp_err += 2;
        drive_bytes();
        check_counts("ovr");

        // Pause sequence, then overrun in idle.
        byte_q = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        exp_pause += 1;
        drive_bytes();
        check_counts("pause");
        query(1'b0, 8'h14, 1'b0);
        query(1'b0, 8'h77, 1'b0);
        byte_q = '{8'hFF};
        exp_err += 1;
        drive_bytes();
        check_counts("ff");

        // Prefix timeout.
        byte_q = '{8'hE0};
        drive_bytes();
        check("to_wait_a", {29'b0, ifa.state_dbg}, {29'b0, EXT});
        idle(TO + 10);
        exp_err += 1;
        check_counts("timeout");
        byte_q = '{8'h1C};
        push_both(ev(8'h1C, 1'b0, 1'b0, 1'b0));
        drive_bytes();
        query(1'b0, 8'h1C, 1'b1);

        // Reset between F0 and the key byte.
        byte_q = '{8'hF0};
        drive_bytes();
        pulse_reset();
        check("mid_rst_code_a", {24'b0, ifa.key_code_out}, 32'd0);
        check_counts("mid_rst");
        query(1'b0, 8'h1C, 1'b0);
        byte_q = '{8'h1C};
        push_both(ev(8'h1C, 1'b0, 1'b0, 1'b0));
        drive_bytes();
        query(1'b0, 8'h1C, 1'b1);

        idle(5);
        check("leftover_a", exp_a.size(), 32'd0);
        check("leftover_b", exp_b.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_parser.md
Name: ps2_scancode_parser

Overview:
- Sits directly downstream of the PS/2 byte decoder.
- Consumes raw Set-2 scan-code bytes, each qualified by a one-cycle valid strobe.
- Assembles prefix sequences (E0 extended, F0 break, E1 pause) into single key events: code, extended flag, make/break.
- Suppresses typematic auto-repeat makes via a pressed-key bitmap, and exposes a random-access "is key held" query for game/UI logic.

Parameters:
- TIMEOUT_CYCLES, 2_000_000, clk_in cycles allowed between a prefix byte and its follow-up byte before the sequence is abandoned (20 ms at 100 MHz).
- SUPPRESS_REPEAT, 1, 1 = drop a make event for a key already marked pressed; 0 = pass repeats through with key_repeat_out=1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- code_in  input  8  scan-code byte from the upstream decoder
- code_valid_in  input  1  one-cycle strobe, code_in valid
- key_code_out  output  8  final (non-prefix) byte of the event
- key_ext_out  output  1  event was E0-prefixed
- key_break_out  output  1  1 = release, 0 = press
- key_repeat_out  output  1  make for an already-held key (only when SUPPRESS_REPEAT=0)
- key_valid_out  output  1  one-cycle event strobe
- pause_out  output  1  one-cycle strobe on a completed 8-byte E1 pause sequence
- err_out  output  1  one-cycle strobe on overrun byte 00/FF, or on a prefix timeout
- query_code_in  input  8  bitmap query code
- query_ext_in  input  1  bitmap query extended flag
- query_pressed_out  output  1  registered; pressed state of {query_ext_in, query_code_in}, 1-cycle latency

Behaviour:
- Reset is level-sensitive and synchronous: any cycle with rst_in=1 resets the block.
  - FSM returns to IDLE.
  - All outputs are 0.
  - All 512 bitmap bits are cleared.
  - Timeout counter and pause counter are 0.
- Reset mid-sequence discards any partial prefix.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (E1 seen, skipping).
- Transitions, evaluated only on code_valid_in:
  - IDLE: E0->EXT; F0->BRK; E1->PAUSE with pause count=1.
  - IDLE: 00/FF -> err_out, stay IDLE. AA/FA/FE/EE -> drop silently.
  - IDLE: any other byte -> make event, ext=0.
  - EXT: F0->EXT_BRK; 12 (fake shift) -> drop, go IDLE; other -> make event, ext=1, go IDLE.
  - BRK: any byte -> break event, ext=0, go IDLE.
  - EXT_BRK: 12 -> drop, go IDLE; other -> break event, ext=1, go IDLE.
  - PAUSE: increment count for each byte, without decoding them. When count reaches 8 (E1 plus 7 bytes), emit pause_out and go IDLE. Pause does not touch the bitmap.
- In BRK, EXT or EXT_BRK, bytes 00/FF emit err_out and return to IDLE instead of forming an event.
- Event timing: outputs are registered. key_valid_out asserts on the cycle after the code_valid_in that completes the event. key_code_out/ext/break/repeat hold their values until the next event.
- Bitmap index is {ext, code}:
  - A make sets the bit; a break clears it.
  - A make on a set bit with SUPPRESS_REPEAT=1 produces no event. With SUPPRESS_REPEAT=0 it produces an event with key_repeat_out=1.
  - A break on a cleared bit still emits the event.
- A bitmap update and a query of the same index in the same cycle: query_pressed_out returns the pre-update value (read-before-write).
- Timeout:
  - The counter runs in every state except IDLE and resets on each code_valid_in.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE, err_out pulses, and no event is emitted.
- Back-to-back code_valid_in on consecutive cycles must be accepted. No internal buffering is required because one byte produces at most one event.

Decomposition:
- ps2_pkg holds:
  - parser_state_t enum.
  - Byte constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT=AA, PS2_ACK=FA, PS2_RESEND=FE, PS2_ECHO=EE, PS2_OVR0=00, PS2_OVR1=FF, PS2_FAKESHIFT=12.
  - PAUSE_LEN=8.
- One sub-module: ps2_key_bitmap, a 512x1 storage with one synchronous write port (set/clear) and two synchronous read ports: the repeat check and the query.

Test Plan:
- Byte 1C -> one key_valid_out, code=1C, ext=0, break=0. Query {0,1C} then returns 1.
- Bytes F0,1C -> event code=1C, ext=0, break=1. Query {0,1C} returns 0.
- Bytes E0,75 then E0,F0,75 -> make then break with ext=1, code=75. Bitmap bit {1,75} is set, then cleared.
- Bytes 1C,1C,1C with SUPPRESS_REPEAT=1 -> exactly one event. With SUPPRESS_REPEAT=0 -> three events, the 2nd and 3rd with key_repeat_out=1.
- Bytes E1,14,77,E1,F0,14,F0,77 -> a single pause_out, no key events, bitmap unchanged. Then byte FF -> err_out pulse, FSM in IDLE.
- Byte E0, then idle for TIMEOUT_CYCLES (set to 100 in the bench) -> err_out and return to IDLE. Next byte 1C -> make with ext=0. Also assert rst_in between F0 and 1C -> no event, and the bitmap is cleared.
